// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port
// Description : Memory-mapped GPIO port with direction, synchronised inputs,
//               set/clear/toggle writes and edge interrupts (W1C status).
// Revision    : 1.0
// ============================================================================
module gpio_port #(
  parameter int          WIDTH       = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wr,
  input  logic             rd,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam int               C_CNT_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(SYNC_STAGES + 1);

  localparam logic [3:0] C_IDX_DOUT   = 4'd0;
  localparam logic [3:0] C_IDX_DIR    = 4'd1;
  localparam logic [3:0] C_IDX_DIN    = 4'd2;
  localparam logic [3:0] C_IDX_SET    = 4'd3;
  localparam logic [3:0] C_IDX_CLR    = 4'd4;
  localparam logic [3:0] C_IDX_TGL    = 4'd5;
  localparam logic [3:0] C_IDX_IERISE = 4'd6;
  localparam logic [3:0] C_IDX_IEFALL = 4'd7;
  localparam logic [3:0] C_IDX_STATUS = 4'd8;

  logic [WIDTH-1:0]   r_data_out;
  logic [WIDTH-1:0]   r_dir;
  logic [WIDTH-1:0]   r_ie_rise;
  logic [WIDTH-1:0]   r_ie_fall;
  logic [WIDTH-1:0]   r_status;
  logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]   r_prev;
  logic [C_CNT_W-1:0] r_cnt;
  logic [31:0]        r_rdata;
  logic               r_irq;

  logic [3:0]       w_idx;
  logic             w_we;
  logic [31:0]      w_bmask;
  logic [31:0]      w_wm;
  logic [WIDTH-1:0] w_bm;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync_in;
  logic             w_settled;
  logic [WIDTH-1:0] w_events;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_dout_nxt;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_idx     = addr[5:2];
  assign w_we      = cs & wr;
  assign w_bmask   = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign w_wm      = wdata & w_bmask;
  assign w_bm      = w_bmask[WIDTH-1:0];
  assign w_wd      = w_wm[WIDTH-1:0];
  assign w_sync_in = r_sync[SYNC_STAGES-1];
  assign w_settled = (r_cnt == C_CNT_MAX);
  assign w_unused  = ^{addr[7:6], addr[1:0], wdata, w_wm, w_bmask};

  // Edges are ignored until the synchroniser and prev stage hold real pin data.
  assign w_events = w_settled ?
                    ((w_sync_in & ~r_prev & r_ie_rise) | (~w_sync_in & r_prev & r_ie_fall)) :
                    '0;
  assign w_w1c    = (w_we && w_idx == C_IDX_STATUS) ? w_wd : '0;

  always_comb begin
    w_dout_nxt = r_data_out;
    if (w_we) begin
      case (w_idx)
        C_IDX_DOUT: w_dout_nxt = (r_data_out & ~w_bm) | w_wd;
        C_IDX_SET:  w_dout_nxt = r_data_out | w_wd;
        C_IDX_CLR:  w_dout_nxt = r_data_out & ~w_wd;
        C_IDX_TGL:  w_dout_nxt = r_data_out ^ w_wd;
        default:    w_dout_nxt = r_data_out;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_idx)
      C_IDX_DOUT:   w_rd[WIDTH-1:0] = r_data_out;
      C_IDX_DIR:    w_rd[WIDTH-1:0] = r_dir;
      C_IDX_DIN:    w_rd[WIDTH-1:0] = w_sync_in;
      C_IDX_IERISE: w_rd[WIDTH-1:0] = r_ie_rise;
      C_IDX_IEFALL: w_rd[WIDTH-1:0] = r_ie_fall;
      C_IDX_STATUS: w_rd[WIDTH-1:0] = r_status;
      default:      w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_in;
      if (!w_settled) r_cnt <= r_cnt + C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= RESET_OUT[WIDTH-1:0];
      r_dir      <= '0;
      r_ie_rise  <= '0;
      r_ie_fall  <= '0;
      r_status   <= '0;
      r_rdata    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_data_out <= w_dout_nxt;
      if (w_we && w_idx == C_IDX_DIR)    r_dir     <= (r_dir & ~w_bm) | w_wd;
      if (w_we && w_idx == C_IDX_IERISE) r_ie_rise <= (r_ie_rise & ~w_bm) | w_wd;
      if (w_we && w_idx == C_IDX_IEFALL) r_ie_fall <= (r_ie_fall & ~w_bm) | w_wd;
      r_status <= (r_status & ~w_w1c) | w_events;
      if (cs && rd) r_rdata <= w_rd;
      r_irq <= |r_status;
    end
  end

  assign rdata    = r_rdata;
  assign gpio_out = r_data_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_port
// Description : Self-checking bench for gpio_port with a read scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_gpio_port;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0]       addr = '0;
  logic [31:0]      wdata = '0;
  logic [3:0]       wmask = '0;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [31:0]      rdata, rdata_a5;
  logic [WIDTH-1:0] gpio_out, gpio_oe, gpio_out_a5, gpio_oe_a5;
  logic             irq, irq_a5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  idx;
  } exp_t;
  exp_t q[$];

  gpio_port #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .RESET_OUT(32'h0)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .wmask(wmask), .rdata(rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq));

  gpio_port #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .RESET_OUT(32'hA5)) dut_a5 (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .wmask(wmask), .rdata(rdata_a5), .gpio_in(gpio_in),
    .gpio_out(gpio_out_a5), .gpio_oe(gpio_oe_a5), .irq(irq_a5));

  always #5 clk = ~clk;

  // Scoreboard: every accepted read pops its expected value one edge later.
  always begin
    @(posedge clk);
    if (cs && rd && !reset) begin
      #1;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL read_scoreboard: read with no expected value, rdata=%h", rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rdata !== e.val) begin
          errors++;
          $display("FAIL read_idx%0d: rdata=%h expected=%h", e.idx, rdata, e.val);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] m);
    cs = 1'b1; wr = 1'b1; addr = {2'b00, idx, 2'b00}; wdata = d; wmask = m;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] idx, input logic [31:0] exp_v);
    exp_t e;
    e.val = exp_v; e.idx = idx;
    q.push_back(e);
    cs = 1'b1; rd = 1'b1; addr = {2'b00, idx, 2'b00};
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_rw(input logic [3:0] idx, input logic [31:0] d, input logic [31:0] exp_v);
    exp_t e;
    e.val = exp_v; e.idx = idx;
    q.push_back(e);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = {2'b00, idx, 2'b00}; wdata = d; wmask = 4'hF;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL rst_oe: got %h exp 00", gpio_oe); end
    checks++; if (gpio_out_a5 !== 8'hA5) begin errors++; $display("FAIL rst_out_a5: got %h exp a5", gpio_out_a5); end
    bus_read(4'd0, 32'h0);
    checks++; if (rdata_a5 !== 32'h0000_00A5) begin errors++; $display("FAIL rst_read_a5: got %h exp 000000a5", rdata_a5); end
    bus_read(4'd1, 32'h0);
    bus_read(4'd6, 32'h0);
    bus_read(4'd7, 32'h0);
    bus_read(4'd8, 32'h0);
  endtask

  task automatic test_set_clr_tgl();
    bus_write(4'd0, 32'h0000_00F0, 4'b0001);
    checks++; if (gpio_out !== 8'hF0) begin errors++; $display("FAIL dout_write: got %h exp f0", gpio_out); end
    bus_write(4'd3, 32'h0000_000F, 4'b0001);
    checks++; if (gpio_out !== 8'hFF) begin errors++; $display("FAIL dout_set: got %h exp ff", gpio_out); end
    bus_write(4'd4, 32'h0000_0081, 4'b0001);
    checks++; if (gpio_out !== 8'h7E) begin errors++; $display("FAIL dout_clr: got %h exp 7e", gpio_out); end
    bus_write(4'd5, 32'h0000_0003, 4'b0001);
    checks++; if (gpio_out !== 8'h7D) begin errors++; $display("FAIL dout_tgl: got %h exp 7d", gpio_out); end
    bus_write(4'd0, 32'hFFFF_FF00, 4'b1110);
    checks++; if (gpio_out !== 8'h7D) begin errors++; $display("FAIL dout_upper_lanes: got %h exp 7d", gpio_out); end
    bus_write(4'd0, 32'h0000_0000, 4'b0000);
    checks++; if (gpio_out !== 8'h7D) begin errors++; $display("FAIL dout_nomask: got %h exp 7d", gpio_out); end
    bus_read(4'd0, 32'h0000_007D);
    bus_read(4'd3, 32'h0);
    bus_read(4'd5, 32'h0);
  endtask

  task automatic test_input();
    gpio_in = 8'h3C;
    bus_read(4'd2, 32'h0);
    bus_read(4'd2, 32'h0);
    bus_read(4'd2, 32'h0000_003C);
    cyc(1);
    checks++; if (rdata !== 32'h0000_003C) begin errors++; $display("FAIL rdata_hold: got %h exp 0000003c", rdata); end
    bus_write(4'd2, 32'h0000_00FF, 4'hF);
    bus_write(4'd9, 32'hFFFF_FFFF, 4'hF);
    bus_read(4'd2, 32'h0000_003C);
    bus_read(4'd0, 32'h0000_007D);
    bus_read(4'd1, 32'h0);
    bus_read(4'd9, 32'h0);
  endtask

  task automatic test_irq();
    int n;
    bus_write(4'd6, 32'h0000_0001, 4'b0001);
    gpio_in = 8'h3D;
    n = 0;
    while (irq !== 1'b1 && n < 10) begin cyc(1); n++; end
    checks++; if (irq !== 1'b1 || n > SYNC + 2) begin errors++; $display("FAIL irq_rise: irq=%b after %0d cycles, need 1 within %0d", irq, n, SYNC + 2); end
    bus_read(4'd8, 32'h0000_0001);
    bus_write(4'd8, 32'h0000_0001, 4'b0001);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b exp 1", irq); end
    cyc(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b exp 0", irq); end
    bus_read(4'd8, 32'h0);
    // Rising edge lands on the same edge as the W1C write.
    gpio_in = 8'h3C;
    cyc(4);
    gpio_in = 8'h3D;
    cyc(2);
    bus_write(4'd8, 32'h0000_0001, 4'b0001);
    bus_read(4'd8, 32'h0000_0001);
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_collide: got %b exp 1", irq); end
    bus_write(4'd6, 32'h0, 4'b0001);
    bus_read(4'd8, 32'h0000_0001);
    bus_write(4'd8, 32'h0000_00FF, 4'b0001);
    bus_read(4'd8, 32'h0);
    bus_write(4'd7, 32'h0000_0004, 4'b0001);
    gpio_in = 8'h39;
    cyc(4);
    bus_read(4'd8, 32'h0000_0004);
    bus_write(4'd8, 32'h0000_0004, 4'b0001);
    bus_write(4'd7, 32'h0, 4'b0001);
    bus_read(4'd8, 32'h0);
  endtask

  task automatic test_settle();
    gpio_in = 8'hFF;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bus_write(4'd6, 32'h0000_00FF, 4'b0001);
    cyc(6);
    bus_read(4'd8, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL settle_irq: got %b exp 0", irq); end
  endtask

  task automatic test_reset_mid();
    bus_write(4'd1, 32'h0000_00FF, 4'b0001);
    bus_write(4'd0, 32'h0000_0055, 4'b0001);
    checks++; if (gpio_oe !== 8'hFF) begin errors++; $display("FAIL mid_dir: got %h exp ff", gpio_oe); end
    gpio_in = 8'hFD;
    cyc(4);
    gpio_in = 8'hFF;
    cyc(4);
    bus_read(4'd8, 32'h0000_0002);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq: got %b exp 1", irq); end
    reset = 1'b1; cs = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 32'hAA; wmask = 4'hF;
    cyc(1);
    reset = 1'b0; cs = 1'b0; wr = 1'b0;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL mid_rst_out: got %h exp 00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL mid_rst_oe: got %h exp 00", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b exp 0", irq); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h exp 0", rdata); end
    bus_read(4'd1, 32'h0);
    bus_read(4'd6, 32'h0);
    bus_read(4'd8, 32'h0);
    bus_write(4'd0, 32'h0000_0055, 4'hF);
    bus_rw(4'd0, 32'h0000_00AA, 32'h0000_0055);
    checks++; if (gpio_out !== 8'hAA) begin errors++; $display("FAIL rw_out: got %h exp aa", gpio_out); end
    bus_read(4'd0, 32'h0000_00AA);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_set_clr_tgl();
    test_input();
    test_irq();
    test_settle();
    test_reset_mid();
    cyc(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
